// File: rtl/cnt_seq_pkg.sv
// Shared types and default sizing for the counter sequencer.
package cnt_seq_pkg;

  localparam int unsigned NUM_SEG_DEF = 4;
  localparam int unsigned LOOP_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_ABORT
  } seq_state_e;

endpackage

// File: rtl/cnt_seq_ctrl.sv
// Counter sequencer: steps the hardware counter through a snapshot of
// threshold slots, repeated for a programmed number of passes.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int unsigned NumSeg = NUM_SEG_DEF,
  parameter int unsigned LoopW  = LOOP_W_DEF,
  localparam int unsigned SegW  = $clog2(NumSeg)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [NumSeg*32-1:0]   seq_thr_i,
  input  logic [SegW-1:0]        seq_last_i,
  input  logic [LoopW-1:0]       seq_loops_i,
  input  logic                   cnt_tc_i,
  output logic                   cnt_en_o,
  output logic                   cnt_clr_o,
  output logic [31:0]            cnt_thr_o,
  output logic                   busy_o,
  output logic [SegW-1:0]        seg_o,
  output logic [LoopW-1:0]       pass_o,
  output logic                   seg_done_o,
  output logic                   done_o
);

  seq_state_e       state_q;
  logic [31:0]      snap_q [NumSeg];
  logic [SegW-1:0]  last_q;
  logic [LoopW-1:0] loops_q;
  logic [SegW-1:0]  seg_q;
  logic [SegW-1:0]  seg_d;
  logic [LoopW-1:0] pass_q;
  logic [LoopW-1:0] pass_d;
  logic [31:0]      thr_q;
  logic             en_q;
  logic             clr_q;
  logic             busy_q;
  logic             seg_done_q;
  logic             done_q;
  logic             last_seg_d;
  logic             pass_end_d;

  // Candidate next segment/pass values and end-of-pass/end-of-sequence tests.
  always_comb begin
    seg_d      = seg_q + SegW'(1);
    pass_d     = (pass_q == '1) ? pass_q : pass_q + LoopW'(1);
    last_seg_d = (seg_q == last_q);
    pass_end_d = (loops_q != '0) && (pass_d == loops_q);
  end

  // Sequencer FSM; every output is registered alongside the state transition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      for (int unsigned i = 0; i < NumSeg; i++) snap_q[i] <= '0;
      last_q     <= '0;
      loops_q    <= '0;
      seg_q      <= '0;
      pass_q     <= '0;
      thr_q      <= '0;
      en_q       <= 1'b0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      seg_done_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      seg_done_q <= 1'b0;
      done_q     <= 1'b0;
      if (abort_i && (state_q inside {ST_LOAD, ST_RUN, ST_DONE})) begin
        // Abort discards any terminal count seen in the same cycle.
        state_q <= ST_ABORT;
        en_q    <= 1'b0;
        clr_q   <= 1'b1;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            en_q  <= 1'b0;
            clr_q <= 1'b0;
            if (start_i) begin
              for (int unsigned i = 0; i < NumSeg; i++) snap_q[i] <= seq_thr_i[i*32 +: 32];
              thr_q   <= seq_thr_i[31:0];
              last_q  <= seq_last_i;
              loops_q <= seq_loops_i;
              seg_q   <= '0;
              pass_q  <= '0;
              state_q <= ST_LOAD;
              clr_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          ST_LOAD: begin
            state_q <= ST_RUN;
            clr_q   <= 1'b0;
            en_q    <= 1'b1;
          end
          ST_RUN: begin
            if (cnt_tc_i) begin
              seg_done_q <= 1'b1;
              en_q       <= 1'b0;
              if (!last_seg_d) begin
                seg_q   <= seg_d;
                thr_q   <= snap_q[seg_d];
                state_q <= ST_LOAD;
                clr_q   <= 1'b1;
              end else begin
                pass_q <= pass_d;
                if (pass_end_d) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end else begin
                  seg_q   <= '0;
                  thr_q   <= snap_q[0];
                  state_q <= ST_LOAD;
                  clr_q   <= 1'b1;
                end
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          ST_ABORT: begin
            state_q <= ST_IDLE;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cnt_en_o   = en_q;
  assign cnt_clr_o  = clr_q;
  assign cnt_thr_o  = thr_q;
  assign busy_o     = busy_q;
  assign seg_o      = seg_q;
  assign pass_o     = pass_q;
  assign seg_done_o = seg_done_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl: a cycle table, directed corner
// sequences, and randomized episodes checked against a segment-list model.
module tb_cnt_seq_ctrl;

  localparam int unsigned NUM_SEG = 4;
  localparam int unsigned LOOP_W  = 8;
  localparam int unsigned SEG_W   = 2;

  localparam int X_LOAD  = 0;
  localparam int X_RUN   = 1;
  localparam int X_DONE  = 2;
  localparam int X_ABORT = 3;
  localparam int X_IDLE  = 4;

  typedef logic [31:0] thr_arr_t [NUM_SEG];

  typedef struct {
    int unsigned seg;
    int unsigned pass;
    logic [31:0] thr;
  } seg_rec_t;

  typedef struct {
    bit          start;
    bit          abort;
    bit          tc;
    bit          en;
    bit          clr;
    bit          busy;
    bit          sd;
    bit          done;
    int unsigned seg;
    int unsigned pass;
    logic [31:0] thr;
  } vec_t;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   start_i = 1'b0;
  logic                   abort_i = 1'b0;
  logic [NUM_SEG*32-1:0]  seq_thr_i = '0;
  logic [SEG_W-1:0]       seq_last_i = '0;
  logic [LOOP_W-1:0]      seq_loops_i = '0;
  logic                   cnt_tc_i;
  logic                   cnt_en_o;
  logic                   cnt_clr_o;
  logic [31:0]            cnt_thr_o;
  logic                   busy_o;
  logic [SEG_W-1:0]       seg_o;
  logic [LOOP_W-1:0]      pass_o;
  logic                   seg_done_o;
  logic                   done_o;

  logic        tc_man_en = 1'b0;
  logic        tc_man = 1'b0;
  logic [31:0] cnt;

  int unsigned checks = 0;
  int unsigned failures = 0;

  cnt_seq_ctrl #(.NumSeg(NUM_SEG), .LoopW(LOOP_W)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .seq_thr_i  (seq_thr_i),
    .seq_last_i (seq_last_i),
    .seq_loops_i(seq_loops_i),
    .cnt_tc_i   (cnt_tc_i),
    .cnt_en_o   (cnt_en_o),
    .cnt_clr_o  (cnt_clr_o),
    .cnt_thr_o  (cnt_thr_o),
    .busy_o     (busy_o),
    .seg_o      (seg_o),
    .pass_o     (pass_o),
    .seg_done_o (seg_done_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Hardware counter model: clear wins, otherwise count while enabled.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt <= 32'd0;
    else if (cnt_clr_o) cnt <= 32'd0;
    else if (cnt_en_o) cnt <= cnt + 32'd1;
  end

  assign cnt_tc_i = tc_man_en ? tc_man : (cnt == cnt_thr_o);

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input thr_arr_t t, input int unsigned last, input int unsigned loops);
    for (int i = 0; i < NUM_SEG; i++) seq_thr_i[i*32 +: 32] = t[i];
    seq_last_i  = SEG_W'(last);
    seq_loops_i = LOOP_W'(loops);
  endtask

  task automatic scramble_cfg();
    for (int i = 0; i < NUM_SEG; i++) seq_thr_i[i*32 +: 32] = $urandom;
    seq_last_i  = SEG_W'($urandom);
    seq_loops_i = LOOP_W'($urandom);
  endtask

  // One full sequence: the model is the ordered list of (seg, pass, thr)
  // segments the configuration implies; the DUT must walk it exactly.
  task automatic run_episode(input thr_arr_t thr, input int unsigned last,
                             input int unsigned loops, input bit do_abort,
                             output int unsigned n_load, output int unsigned n_done);
    seg_rec_t    q[$];
    seg_rec_t    cur;
    int          x;
    int unsigned run_len;
    int unsigned abort_at;
    bit          sd_exp;
    bit          fin;
    n_load  = 0;
    n_done  = 0;
    run_len = 0;
    for (int unsigned p = 0; p < loops; p++)
      for (int unsigned s = 0; s <= last; s++)
        q.push_back('{seg: s, pass: p, thr: thr[s]});
    cur = q[0];
    set_cfg(thr, last, loops);
    tc_man_en = 1'b0;
    abort_i   = 1'b0;
    start_i   = 1'b1;
    tick();
    start_i  = 1'b0;
    x        = X_LOAD;
    sd_exp   = 1'b0;
    fin      = 1'b0;
    abort_at = do_abort ? $urandom_range(2, 40) : 0;
    for (int unsigned cyc = 0; cyc < 3000 && !fin; cyc++) begin
      case (x)
        X_LOAD: begin
          chk("load_clr", 32'(cnt_clr_o), 1);
          chk("load_en", 32'(cnt_en_o), 0);
          chk("load_busy", 32'(busy_o), 1);
          chk("load_seg_done", 32'(seg_done_o), 32'(sd_exp));
          chk("load_done", 32'(done_o), 0);
          cur = q.pop_front();
          chk("load_thr", cnt_thr_o, cur.thr);
          chk("load_seg", 32'(seg_o), cur.seg);
          chk("load_pass", 32'(pass_o), cur.pass);
          n_load++;
          run_len = 0;
          x = X_RUN;
        end
        X_RUN: begin
          chk("run_en", 32'(cnt_en_o), 1);
          chk("run_clr", 32'(cnt_clr_o), 0);
          chk("run_seg_done", 32'(seg_done_o), 0);
          chk("run_done", 32'(done_o), 0);
          chk("run_thr_held", cnt_thr_o, cur.thr);
          chk("run_seg", 32'(seg_o), cur.seg);
          run_len++;
          if (do_abort && cyc >= abort_at) begin
            x = X_ABORT;
          end else if (cnt_tc_i) begin
            chk("seg_len", run_len, cur.thr + 1);
            sd_exp = 1'b1;
            x = (q.size() != 0) ? X_LOAD : X_DONE;
          end
        end
        X_DONE: begin
          chk("done_pulse", 32'(done_o), 1);
          chk("done_seg_done", 32'(seg_done_o), 1);
          chk("done_en", 32'(cnt_en_o), 0);
          chk("done_clr", 32'(cnt_clr_o), 0);
          chk("done_busy", 32'(busy_o), 1);
          chk("done_pass", 32'(pass_o), loops);
          chk("done_seg", 32'(seg_o), last);
          n_done++;
          x = X_IDLE;
        end
        X_ABORT: begin
          chk("abort_clr", 32'(cnt_clr_o), 1);
          chk("abort_en", 32'(cnt_en_o), 0);
          chk("abort_busy", 32'(busy_o), 1);
          chk("abort_seg_done", 32'(seg_done_o), 0);
          chk("abort_done", 32'(done_o), 0);
          chk("abort_seg", 32'(seg_o), cur.seg);
          x = X_IDLE;
        end
        default: begin
          chk("idle_busy", 32'(busy_o), 0);
          chk("idle_en", 32'(cnt_en_o), 0);
          chk("idle_clr", 32'(cnt_clr_o), 0);
          chk("idle_done", 32'(done_o), 0);
          fin = 1'b1;
        end
      endcase
      if (!fin) begin
        abort_i = (x == X_ABORT);
        start_i = ($urandom_range(0, 3) == 0);
        scramble_cfg();
        tick();
      end
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("episode_timeout", 32'(fin), 1);
  endtask

  vec_t        tv[13];
  thr_arr_t    thr;
  int unsigned n_load;
  int unsigned n_done;
  int unsigned seen_done;
  int unsigned n_clr;
  bit          reached;

  initial begin
    // Reset state.
    rst_ni = 1'b0;
    tick();
    tick();
    chk("rst_en", 32'(cnt_en_o), 0);
    chk("rst_clr", 32'(cnt_clr_o), 0);
    chk("rst_thr", cnt_thr_o, 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_seg", 32'(seg_o), 0);
    chk("rst_pass", 32'(pass_o), 0);
    chk("rst_seg_done", 32'(seg_done_o), 0);
    chk("rst_done", 32'(done_o), 0);
    rst_ni = 1'b1;
    tick();

    // Cycle table with manually driven terminal count: two-segment single
    // pass, ignored start while busy, abort in DONE/IDLE, start+abort in
    // IDLE, and tc coinciding with abort.
    thr = '{32'd5, 32'd3, 32'd7, 32'd1};
    set_cfg(thr, 1, 1);
    //         st ab tc  en clr bsy sd dn seg pass thr
    tv[0]  = '{1, 0, 0,  0, 1,  1,  0, 0, 0,  0,   5};
    tv[1]  = '{0, 0, 0,  1, 0,  1,  0, 0, 0,  0,   5};
    tv[2]  = '{0, 0, 1,  0, 1,  1,  1, 0, 1,  0,   3};
    tv[3]  = '{1, 0, 0,  1, 0,  1,  0, 0, 1,  0,   3};
    tv[4]  = '{0, 0, 0,  1, 0,  1,  0, 0, 1,  0,   3};
    tv[5]  = '{0, 0, 1,  0, 0,  1,  1, 1, 1,  1,   3};
    tv[6]  = '{0, 1, 0,  0, 1,  1,  0, 0, 1,  1,   3};
    tv[7]  = '{0, 1, 0,  0, 0,  0,  0, 0, 1,  1,   3};
    tv[8]  = '{0, 1, 0,  0, 0,  0,  0, 0, 1,  1,   3};
    tv[9]  = '{1, 1, 0,  0, 1,  1,  0, 0, 0,  0,   5};
    tv[10] = '{0, 0, 0,  1, 0,  1,  0, 0, 0,  0,   5};
    tv[11] = '{0, 1, 1,  0, 1,  1,  0, 0, 0,  0,   5};
    tv[12] = '{0, 0, 0,  0, 0,  0,  0, 0, 0,  0,   5};
    tc_man_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      start_i = tv[i].start;
      abort_i = tv[i].abort;
      tc_man  = tv[i].tc;
      tick();
      chk($sformatf("tv%0d_en", i), 32'(cnt_en_o), 32'(tv[i].en));
      chk($sformatf("tv%0d_clr", i), 32'(cnt_clr_o), 32'(tv[i].clr));
      chk($sformatf("tv%0d_busy", i), 32'(busy_o), 32'(tv[i].busy));
      chk($sformatf("tv%0d_seg_done", i), 32'(seg_done_o), 32'(tv[i].sd));
      chk($sformatf("tv%0d_done", i), 32'(done_o), 32'(tv[i].done));
      chk($sformatf("tv%0d_seg", i), 32'(seg_o), tv[i].seg);
      chk($sformatf("tv%0d_pass", i), 32'(pass_o), tv[i].pass);
      chk($sformatf("tv%0d_thr", i), cnt_thr_o, tv[i].thr);
    end
    start_i   = 1'b0;
    abort_i   = 1'b0;
    tc_man    = 1'b0;
    tc_man_en = 1'b0;

    // Two segments (5 then 3), single pass, driven by the counter model.
    run_episode(thr, 1, 1, 1'b0, n_load, n_done);
    chk("two_seg_loads", n_load, 2);
    chk("two_seg_dones", n_done, 1);

    // One segment, three passes.
    thr = '{32'd2, 32'd0, 32'd0, 32'd0};
    run_episode(thr, 0, 3, 1'b0, n_load, n_done);
    chk("three_pass_loads", n_load, 3);
    chk("three_pass_dones", n_done, 1);

    // Endless mode: many passes, pass count saturates, never done, then abort.
    thr = '{32'd4, 32'd4, 32'd4, 32'd4};
    set_cfg(thr, 0, 0);
    start_i = 1'b1;
    tick();
    start_i   = 1'b0;
    seen_done = 0;
    n_clr     = 0;
    reached   = 1'b0;
    for (int c = 0; c < 2500 && !reached; c++) begin
      if (done_o) seen_done++;
      if (cnt_clr_o) n_clr++;
      if (pass_o == 8'd255) reached = 1'b1;
      else tick();
    end
    chk("loop0_reached_max", 32'(reached), 1);
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done_o) seen_done++;
    end
    chk("loop0_pass_saturated", 32'(pass_o), 255);
    chk("loop0_no_done", seen_done, 0);
    chk("loop0_many_loads", 32'(n_clr > 10), 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("loop0_abort_clr", 32'(cnt_clr_o), 1);
    chk("loop0_abort_en", 32'(cnt_en_o), 0);
    chk("loop0_abort_busy", 32'(busy_o), 1);
    chk("loop0_abort_done", 32'(done_o), 0);
    tick();
    chk("loop0_idle_busy", 32'(busy_o), 0);
    chk("loop0_idle_clr", 32'(cnt_clr_o), 0);
    chk("loop0_idle_pass_held", 32'(pass_o), 255);

    // Randomized episodes with config churn, stray starts and random aborts.
    for (int e = 0; e < 25; e++) begin
      for (int i = 0; i < NUM_SEG; i++) thr[i] = $urandom_range(0, 6);
      run_episode(thr, $urandom_range(0, 3), $urandom_range(1, 3),
                  ($urandom_range(0, 2) == 0), n_load, n_done);
      tick();
    end

    // Asynchronous reset in the middle of a run.
    thr = '{32'd20, 32'd20, 32'd20, 32'd20};
    set_cfg(thr, 1, 2);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    chk("pre_rst_en", 32'(cnt_en_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_en", 32'(cnt_en_o), 0);
    chk("async_rst_clr", 32'(cnt_clr_o), 0);
    chk("async_rst_busy", 32'(busy_o), 0);
    chk("async_rst_thr", cnt_thr_o, 0);
    chk("async_rst_seg", 32'(seg_o), 0);
    chk("async_rst_pass", 32'(pass_o), 0);
    rst_ni = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", 32'(busy_o), 0);
    chk("post_rst_en", 32'(cnt_en_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnt_seq_ctrl.md
# cnt_seq_ctrl

Sequencer that drives the hardware counter through a programmed list of threshold segments, repeated for a programmed number of passes. It sits between the counter control registers (which supply the configuration and start/abort strobes) and the hardware counter, replacing direct software control of the counter's enable, clear and threshold inputs. It reports progress (segment, pass) and emits per-segment and end-of-sequence pulses suitable for interrupts.

## Interface
- `NumSeg`, 4: number of threshold slots (≥2, power of two).
- `LoopW`, 8: width of the pass counter.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  1  start pulse; ignored while `busy_o`.
- `abort_i`  in  1  abort pulse; highest priority.
- `seq_thr_i`  in  NumSeg×32  threshold per slot.
- `seq_last_i`  in  $clog2(NumSeg)  index of last active slot.
- `seq_loops_i`  in  LoopW  number of passes; 0 = run until abort.
- `cnt_tc_i`  in  1  counter terminal-count level.
- `cnt_en_o`  out  1  counter enable.
- `cnt_clr_o`  out  1  counter clear.
- `cnt_thr_o`  out  32  counter threshold.
- `busy_o`  out  1  sequence active.
- `seg_o`  out  $clog2(NumSeg)  current slot index.
- `pass_o`  out  LoopW  completed passes.
- `seg_done_o`  out  1  one-cycle pulse per finished segment.
- `done_o`  out  1  one-cycle pulse at sequence end (not on abort).

## Operation
- States: IDLE, LOAD, RUN, DONE, ABORT. Reset → IDLE; all outputs 0.
- IDLE: en=0, clr=0. `start_i` → LOAD; snapshot `seq_thr_i`, `seq_last_i`, `seq_loops_i`; seg=0, pass=0. Config changes after start have no effect.
- LOAD (1 cycle): clr=1, en=0, `cnt_thr_o`=snapshot[seg] (registered, held until next LOAD). → RUN.
- RUN: en=1. On `cnt_tc_i`=1: seg_done pulse next cycle; if seg<last → seg+1, LOAD; else pass+1 (saturating at max), and if `seq_loops_i`≠0 and new pass == loops → DONE, else seg=0, LOAD.
- DONE (1 cycle): done_o=1, en=0, busy=1. → IDLE.
- `abort_i` in LOAD/RUN/DONE → ABORT (clr=1, en=0, 1 cycle) → IDLE; no `seg_done_o`/`done_o` for that cycle's tc. Abort in IDLE ignored.
- `start_i` while busy ignored; start and abort same cycle in IDLE → start wins (abort ignored in IDLE).
- `seq_last_i` > NumSeg-1 impossible by width; seg wraps to 0 only via pass end.
- `busy_o` = state ≠ IDLE. `seg_o`, `pass_o` hold last values in IDLE until next start.

## Timing
- Start sampled at edge of cycle 0: cycle 1 LOAD (clr=1), cycle 2 first RUN cycle (en=1).
- tc high in cycle k (RUN): cycle k+1 en=0 and seg_done_o=1, state LOAD or DONE; next segment RUN at k+2. Per-segment overhead: 1 cycle.
- Last segment of last pass, tc at k: done_o=1 at k+1, busy_o=0 at k+2.
- Abort sampled at k: ABORT at k+1 (clr=1), IDLE at k+2.
- All outputs registered or decoded from state registers only; no combinational path input → output.

## Structure
- Package `cnt_seq_pkg`: state enum type, default `NumSeg`/`LoopW` constants.
- Single module, no sub-module; snapshot register array, seg/pass counters, FSM.

## Test plan
- thr={5,3,…}, last=1, loops=1, counter model tc at count==thr: seg_done pulses after 5 and 3 counts, cnt_thr_o 5 then 3, one done_o, busy drops 2 cycles after final tc.
- last=0, loops=3, thr[0]=2: exactly 3 LOAD/clear pulses, pass_o 1,2,3, single done_o.
- loops=0, thr[0]=4: runs >10 passes without done_o; abort → clr pulse, IDLE, no done_o.
- Change seq_thr_i to 9 mid-run: cnt_thr_o remains snapshot value until next start.
- start_i during RUN and abort_i in IDLE: no state change; tc and abort same cycle → ABORT, no seg_done_o.
- Reset asserted mid-RUN: all outputs 0 immediately, IDLE after release.
